// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one framebuffer RAM between display fetch (priority) and a FIFO-buffered pixel writer
module vga_fb_arbiter #(
  parameter int AW = 19,
  parameter int DW = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CW = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          disp_req,
  input  logic [AW-1:0]                 disp_addr,
  output logic [DW-1:0]                 disp_data,
  output logic                          disp_valid,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [AW-1:0]                 wr_addr,
  input  logic [DW-1:0]                 wr_data,
  output logic [AW-1:0]                 ram_addr,
  output logic                          ram_we,
  output logic [DW-1:0]                 ram_wdata,
  input  logic [DW-1:0]                 ram_rdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CW-1:0]                 defer_cnt
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  logic [AW-1:0] q_addr [FIFO_DEPTH];
  logic [DW-1:0] q_data [FIFO_DEPTH];
  logic [PW-1:0] wp, rp;
  logic [AW-1:0] last_addr;
  logic          rd_pend, push, pop, nonempty;
  assign nonempty = fifo_level != '0;
  assign wr_ready = fifo_level != LW'(FIFO_DEPTH);
  assign push     = wr_valid && wr_ready;
  assign pop      = !disp_req && nonempty;
  always_comb begin
    ram_we    = pop;
    ram_wdata = pop ? q_data[rp] : '0;
    ram_addr  = reset ? '0 : disp_req ? disp_addr : pop ? q_addr[rp] : last_addr;
  end
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wp] <= wr_addr;
      q_data[wp] <= wr_data;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp         <= '0;
      rp         <= '0;
      fifo_level <= '0;
      last_addr  <= '0;
      rd_pend    <= 1'b0;
      disp_valid <= 1'b0;
      disp_data  <= '0;
      defer_cnt  <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      fifo_level <= fifo_level + LW'(push) - LW'(pop);
      last_addr  <= ram_addr;
      rd_pend    <= disp_req;
      disp_valid <= rd_pend;
      if (rd_pend) disp_data <= ram_rdata;
      if (disp_req && nonempty && defer_cnt != '1) defer_cnt <= defer_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: directed scoreboard bench for vga_fb_arbiter with a behavioural RAM and FIFO model
module tb_vga_fb_arbiter;
  localparam int AW = 19;
  localparam int DW = 8;
  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  typedef struct { int due; logic [DW-1:0] d; } rd_t;
  logic clk = 1'b0, reset = 1'b1;
  logic disp_req = 1'b0, wr_valid = 1'b0;
  logic [AW-1:0] disp_addr = '0, wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] disp_data, ram_wdata, ram_rdata;
  logic disp_valid, wr_ready, ram_we;
  logic [AW-1:0] ram_addr;
  logic [2:0] fifo_level;
  logic [3:0] defer_cnt;
  logic [DW-1:0] mem [1024] = '{5: 8'h1C, default: 8'h00};
  wr_t mq[$];
  rd_t dq[$];
  int tests = 0, fails = 0, cyc = 0, m_defer = 0, p = 0, guard = 0;
  logic [AW-1:0] m_last = '0;
  logic acc;

  vga_fb_arbiter #(.AW(AW), .DW(DW), .FIFO_DEPTH(4), .CW(4)) dut (
    .clk(clk), .reset(reset), .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_data(disp_data), .disp_valid(disp_valid), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .fifo_level(fifo_level), .defer_cnt(defer_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr[9:0]] <= ram_wdata;
    ram_rdata <= mem[ram_addr[9:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: drive, check outputs mid-cycle, then advance the model to the next edge.
  task automatic cycle(input logic dr, input logic [AW-1:0] da, input logic wv,
                       input logic [AW-1:0] wa, input logic [DW-1:0] wd, output logic ok);
    logic ready, we;
    logic [AW-1:0] ea;
    disp_req = dr; disp_addr = da; wr_valid = wv; wr_addr = wa; wr_data = wd;
    @(negedge clk);
    ready = mq.size() != 4;
    we = !dr && mq.size() > 0;
    ea = dr ? da : we ? mq[0].a : m_last;
    chk("wr_ready", 32'(wr_ready), 32'(ready));
    chk("fifo_level", 32'(fifo_level), mq.size());
    chk("ram_we", 32'(ram_we), 32'(we));
    chk("ram_addr", 32'(ram_addr), 32'(ea));
    if (we) chk("ram_wdata", 32'(ram_wdata), 32'(mq[0].d));
    if (dq.size() > 0 && dq[0].due == cyc) begin
      chk("disp_valid", 32'(disp_valid), 1);
      chk("disp_data", 32'(disp_data), 32'(dq[0].d));
      void'(dq.pop_front());
    end else chk("disp_valid", 32'(disp_valid), 0);
    chk("defer_cnt", 32'(defer_cnt), m_defer);
    if (dr && mq.size() > 0 && m_defer != 15) m_defer++;
    if (dr) dq.push_back('{cyc + 2, mem[da[9:0]]});
    if (we) void'(mq.pop_front());
    ok = wv && ready;
    if (ok) mq.push_back('{wa, wd});
    m_last = ea;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_ready", 32'(wr_ready), 1);
    chk("rst_valid", 32'(disp_valid), 0);
    chk("rst_data", 32'(disp_data), 0);
    chk("rst_defer", 32'(defer_cnt), 0);
    chk("rst_we", 32'(ram_we), 0);
    reset = 1'b0;
    // single write on an idle display
    cycle(0, 0, 1, 19'h00010, 8'hE0, acc);
    cycle(0, 0, 0, 0, 0, acc);
    cycle(0, 0, 0, 0, 0, acc);
    // display read, data two cycles later
    cycle(1, 19'd5, 0, 0, 0, acc);
    cycle(0, 0, 0, 0, 0, acc);
    cycle(0, 0, 0, 0, 0, acc);
    cycle(0, 0, 0, 0, 0, acc);
    cycle(1, 19'h00010, 0, 0, 0, acc);
    cycle(1, 19'd5, 0, 0, 0, acc);
    cycle(0, 0, 0, 0, 0, acc);
    cycle(0, 0, 0, 0, 0, acc);
    // display burst starves six offered writes
    p = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1, 19'(100 + i), p < 6, 19'(200 + p), 8'(8'h30 + p), acc);
      if (acc) p++;
    end
    chk("t4_accepted", p, 4);
    chk("t4_defer", 32'(defer_cnt), 9);
    guard = 0;
    while ((p < 6 || mq.size() > 0) && guard < 20) begin
      cycle(0, 0, p < 6, 19'(200 + p), 8'(8'h30 + p), acc);
      if (acc) p++;
      guard++;
    end
    chk("t4_drained", guard < 20, 1);
    // full FIFO: pop refuses push, next cycle accepts
    for (int i = 0; i < 4; i++) cycle(1, 19'd7, 1, 19'(300 + i), 8'(8'h40 + i), acc);
    chk("t5_full", 32'(fifo_level), 4);
    cycle(0, 0, 1, 19'd304, 8'h44, acc);
    chk("t5_refused", 32'(acc), 0);
    cycle(1, 19'd8, 1, 19'd304, 8'h44, acc);
    chk("t5_level", 32'(fifo_level), 4);
    // saturating deferral counter
    for (int i = 0; i < 20; i++) cycle(1, 19'(i), 0, 0, 0, acc);
    chk("t6_sat", 32'(defer_cnt), 15);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 0, acc);
    // mid-stream reset with three queued entries and a read in flight
    for (int i = 0; i < 3; i++) cycle(1, 19'd9, 1, 19'(400 + i), 8'(8'h50 + i), acc);
    chk("t1_pre", 32'(fifo_level), 3);
    disp_req = 0; wr_valid = 0;
    reset = 1'b1;
    #1;
    chk("t1_level", 32'(fifo_level), 0);
    chk("t1_ready", 32'(wr_ready), 1);
    chk("t1_we", 32'(ram_we), 0);
    chk("t1_valid", 32'(disp_valid), 0);
    chk("t1_addr", 32'(ram_addr), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    mq.delete(); dq.delete(); m_defer = 0; m_last = '0;
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 0, acc);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
